// File: rtl/multi_digit_counter.sv
// Cascaded up/down digit counter with load, per-digit carry and wrap flags.
// Define MULTI_DIGIT_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module multi_digit_counter #(
  parameter int DIGITS = 4,
  parameter int MODULO = 10,
  localparam int W = $clog2(MODULO)
) (
  input  logic                clkIn,
  input  logic                resetIn,
  input  logic                enableIn,
  input  logic                upIn,
  input  logic                loadIn,
  input  logic [DIGITS*W-1:0] loadValueIn,
  output logic [DIGITS*W-1:0] digitsOut,
  output logic [DIGITS-1:0]   carryOut,
  output logic                overflowOut,
  output logic                underflowOut
);

`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [W-1:0] MAX = W'(MODULO - 1);

  typedef enum logic [1:0] {
    RESET,
    COUNT,
    WRAP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIGITS*W-1:0] r_dig;
  logic [DIGITS*W-1:0] w_dig_nxt;
  logic [DIGITS*W-1:0] w_dig_step;
  logic [DIGITS*W-1:0] w_dig_load;
  logic [DIGITS-1:0]   r_car;
  logic [DIGITS-1:0]   w_car_nxt;
  logic [DIGITS-1:0]   w_car_step;
  logic                r_dir;
  logic                w_dir_nxt;
  logic                w_full;

  // A digit steps only when every digit below it sits at its wrap point
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    logic [W-1:0] w_d;
    logic [W-1:0] w_f;
    logic         w_in;
    logic         w_edge;
    logic         w_out;

    if (g == 0) begin : g_first
      assign w_in = 1'b1;
    end else begin : g_rest
      assign w_in = g_dig[g-1].w_out;
    end

    assign w_d    = r_dig[g*W +: W];
    assign w_edge = upIn ? (w_d == MAX) : (w_d == '0);
    assign w_out  = w_in & w_edge;

    assign w_car_step[g] = w_out;
    assign w_dig_step[g*W +: W] =
      !w_in  ? w_d :
      w_edge ? (upIn ? '0 : MAX) :
      upIn   ? w_d + 1'b1 : w_d - 1'b1;

    assign w_f = loadValueIn[g*W +: W];
    assign w_dig_load[g*W +: W] =
      ({1'b0, w_f} >= (W+1)'(MODULO)) ? MAX : w_f;
  end

  assign w_full = g_dig[DIGITS-1].w_out;

  always_comb begin
    w_state_nxt = COUNT;
    w_dig_nxt   = r_dig;
    w_car_nxt   = '0;
    w_dir_nxt   = r_dir;
    // A saturated counter keeps its sticky flag while idle
    if (SAT && r_state == WRAP) begin
      w_state_nxt = WRAP;
    end
    if (loadIn) begin
      w_state_nxt = COUNT;
      w_dig_nxt   = w_dig_load;
    end else if (enableIn) begin
      w_state_nxt = w_full ? WRAP : COUNT;
      if (w_full) begin
        w_dir_nxt = upIn;
      end
      if (!(SAT && w_full)) begin
        w_dig_nxt = w_dig_step;
        w_car_nxt = w_car_step;
      end
    end
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      r_state <= RESET;
      r_dig   <= '0;
      r_car   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dig   <= w_dig_nxt;
      r_car   <= w_car_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  assign digitsOut    = r_dig;
  assign carryOut     = r_car;
  assign overflowOut  = (r_state == WRAP) &  r_dir;
  assign underflowOut = (r_state == WRAP) & ~r_dir;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Bench for multi_digit_counter: 4x mod-10 and 2x mod-6 instances
// checked against an integer-valued reference model.
module tb_multi_digit_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_en = 1'b0;
  logic        a_up = 1'b0;
  logic        a_ld = 1'b0;
  logic [15:0] a_lv = '0;
  logic [15:0] a_dig;
  logic [3:0]  a_car;
  logic        a_ov;
  logic        a_un;

  logic        b_en = 1'b0;
  logic        b_up = 1'b0;
  logic        b_ld = 1'b0;
  logic [5:0]  b_lv = '0;
  logic [5:0]  b_dig;
  logic [1:0]  b_car;
  logic        b_ov;
  logic        b_un;

  multi_digit_counter u_a (
    .clkIn       (clk),
    .resetIn     (rst_n),
    .enableIn    (a_en),
    .upIn        (a_up),
    .loadIn      (a_ld),
    .loadValueIn (a_lv),
    .digitsOut   (a_dig),
    .carryOut    (a_car),
    .overflowOut (a_ov),
    .underflowOut(a_un)
  );

  multi_digit_counter #(
    .DIGITS(2),
    .MODULO(6)
  ) u_b (
    .clkIn       (clk),
    .resetIn     (rst_n),
    .enableIn    (b_en),
    .upIn        (b_up),
    .loadIn      (b_ld),
    .loadValueIn (b_lv),
    .digitsOut   (b_dig),
    .carryOut    (b_car),
    .overflowOut (b_ov),
    .underflowOut(b_un)
  );

  int n_chk = 0;
  int n_pass = 0;

  int av = 0;
  int bv = 0;
  int acar = 0;
  int bcar = 0;
  bit aov = 0;
  bit aun = 0;
  bit bov = 0;
  bit bun = 0;

  function automatic int pw(int m, int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * m;
    return r;
  endfunction

  function automatic int clampv(int d, int m, int w,
                                logic [31:0] lv);
    int r = 0;
    for (int k = 0; k < d; k++) begin
      int f;
      f = int'((lv >> (k*w)) & ((32'd1 << w) - 1));
      if (f > m - 1) f = m - 1;
      r = r + f * pw(m, k);
    end
    return r;
  endfunction

  function automatic logic [31:0] pack(int d, int m, int w, int v);
    logic [31:0] r = '0;
    for (int k = 0; k < d; k++)
      r = r | (32'((v / pw(m, k)) % m) << (k*w));
    return r;
  endfunction

  // Counter value as a plain integer in 0 .. MODULO**DIGITS-1
  task automatic mdl(input int d, input int m, inout int v,
                     inout bit ov, inout bit un, output int car,
                     input bit ld, input int lvc,
                     input bit en, input bit up);
    int n;
    bit full;
    bit hold;
    n = pw(m, d);
    car = 0;
    hold = 0;
    if (ld) begin
      v = lvc;
      ov = 0;
      un = 0;
    end else if (en) begin
      full = up ? (v == n - 1) : (v == 0);
`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
      hold = full;
`endif
      if (hold) begin
        ov = up;
        un = !up;
      end else begin
        for (int k = 0; k < d; k++)
          if (up ? ((v + 1) % pw(m, k + 1)) == 0
                 : (v % pw(m, k + 1)) == 0)
            car = car | (1 << k);
        v = up ? (v + 1) % n : (v + n - 1) % n;
        ov = up && full;
        un = !up && full;
      end
    end else begin
`ifndef MULTI_DIGIT_COUNTER_SATURATE_EN
      ov = 0;
      un = 0;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    av = 0; aov = 0; aun = 0; acar = 0;
    bv = 0; bov = 0; bun = 0; bcar = 0;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    mdl(4, 10, av, aov, aun, acar, a_ld,
        clampv(4, 10, 4, 32'(a_lv)), a_en, a_up);
    mdl(2, 6, bv, bov, bun, bcar, b_ld,
        clampv(2, 6, 3, 32'(b_lv)), b_en, b_up);
    #1;
    chk({tag, "/a.dig"}, 32'(a_dig), pack(4, 10, 4, av));
    chk({tag, "/a.car"}, 32'(a_car), 32'(acar));
    chk({tag, "/a.ov"}, 32'(a_ov), 32'(aov));
    chk({tag, "/a.un"}, 32'(a_un), 32'(aun));
    chk({tag, "/b.dig"}, 32'(b_dig), pack(2, 6, 3, bv));
    chk({tag, "/b.car"}, 32'(b_car), 32'(bcar));
    chk({tag, "/b.ov"}, 32'(b_ov), 32'(bov));
    chk({tag, "/b.un"}, 32'(b_un), 32'(bun));
  endtask

  task automatic set_a(input bit ld, input logic [15:0] lv,
                       input bit en, input bit up);
    a_ld = ld; a_lv = lv; a_en = en; a_up = up;
  endtask

  task automatic set_b(input bit ld, input logic [5:0] lv,
                       input bit en, input bit up);
    b_ld = ld; b_lv = lv; b_en = en; b_up = up;
  endtask

  int b_ovc;

  initial begin
    // reset held across two clock edges with enable high
    set_a(0, '0, 1, 1);
    #17;
    chk("rst.dig", 32'(a_dig), 32'h0);
    chk("rst.car", 32'(a_car), 32'h0);
    chk("rst.ov", 32'(a_ov), 32'h0);
    chk("rst.un", 32'(a_un), 32'h0);
    set_a(0, '0, 0, 1);
    #1 rst_n = 1'b1;
    model_reset();

    set_a(1, 16'h1234, 1, 1);
    tick("ldprio");
    chk("ldprio.const", 32'(a_dig), 32'h1234);
    set_a(1, 16'h000F, 0, 1);
    tick("clamp");
    chk("clamp.const", 32'(a_dig), 32'h0009);

    set_a(1, 16'h0999, 0, 1);
    tick("ld0999");
    set_a(0, '0, 1, 1);
    tick("casc");
    chk("casc.dig", 32'(a_dig), 32'h1000);
    chk("casc.car", 32'(a_car), 32'b0111);
    chk("casc.ov", 32'(a_ov), 32'h0);

    set_a(1, 16'h9999, 0, 1);
    tick("ld9999");
    set_a(0, '0, 1, 1);
    tick("wrap");
    set_a(0, '0, 0, 1);
    tick("wrapidle");
`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
    chk("sat.dig", 32'(a_dig), 32'h9999);
    chk("sat.ov", 32'(a_ov), 32'h1);
    set_a(0, '0, 1, 0);
    tick("satdown");
    chk("satdown.dig", 32'(a_dig), 32'h9998);
    chk("satdown.ov", 32'(a_ov), 32'h0);
`else
    chk("wrap.ov1cyc", 32'(a_ov), 32'h0);
    chk("wrap.dig", 32'(a_dig), 32'h0000);
`endif

    set_a(1, 16'h0000, 0, 0);
    tick("ld0000");
    set_a(0, '0, 1, 0);
    tick("under");
    set_a(0, '0, 1, 1);
    tick("underup");

    set_a(1, 16'h0000, 0, 1);
    tick("ld0");
    set_a(0, '0, 1, 1);
    for (int i = 0; i < 42; i++) tick("cnt42");
    chk("cnt42.const", 32'(a_dig), 32'h0042);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.dig", 32'(a_dig), 32'h0);
    chk("midrst.car", 32'(a_car), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst.hold", 32'(a_dig), 32'h0);
    #4 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick("post");
    chk("post.const", 32'(a_dig), 32'h0003);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] lv;
      case ($urandom % 4)
        0: lv = 16'h9999;
        1: lv = 16'h0000;
        default: lv = 16'($urandom);
      endcase
      set_a(($urandom % 8) == 0, lv,
            ($urandom % 4) != 0, 1'($urandom));
      tick("rand");
    end
    set_a(0, '0, 0, 1);

    set_b(1, 6'o55, 0, 1);
    tick("b.ld55");
    set_b(0, '0, 1, 1);
    tick("b.wrap");
`ifndef MULTI_DIGIT_COUNTER_SATURATE_EN
    chk("b.wrap.dig", 32'(b_dig), 32'h0);
    chk("b.wrap.ov", 32'(b_ov), 32'h1);
`endif
    set_b(1, 6'o00, 0, 1);
    tick("b.ld00");
    set_b(0, '0, 1, 1);
    b_ovc = 0;
    for (int i = 0; i < 36; i++) begin
      tick("b.run");
      if (b_ov) b_ovc++;
    end
    chk("b.ovcount", 32'(b_ovc), 32'd1);
`ifdef MULTI_DIGIT_COUNTER_SATURATE_EN
    chk("b.final", 32'(b_dig), 32'o55);
`else
    chk("b.final", 32'(b_dig), 32'o00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_digit_counter.md
MULTI_DIGIT_COUNTER -- requirements
Module: multi_digit_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded digits; legal range 1..8.
REQ-002 Parameter MODULO, default 10: states per digit; legal range 2..16.
REQ-003 Localparam W = $clog2(MODULO): bits per digit.
REQ-004 clkIn  input  1  system clock; all state changes on its rising edge, except reset.
REQ-005 resetIn  input  1  reset, asynchronous, active-low.
REQ-006 enableIn  input  1  step qualifier; one count step per clock when high.
REQ-007 upIn  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 loadIn  input  1  synchronous parallel load strobe.
REQ-009 loadValueIn  input  DIGITS*W  load value; digit 0 in the LSBs.
REQ-010 digitsOut  output  DIGITS*W  registered count; digit 0 in the LSBs.
REQ-011 carryOut  output  DIGITS  registered per-digit pulse; bit k = digit k wrapped on the last step (carry or borrow).
REQ-012 overflowOut  output  1  registered; whole counter wrapped upward.
REQ-013 underflowOut  output  1  registered; whole counter wrapped downward.

Function
REQ-014 Fully synchronous single-clock design; no ripple clocking between digits.
REQ-015 Priority per cycle: loadIn over enableIn.
REQ-016 Load: the cycle after loadIn is sampled high, each digit equals its loadValueIn field.
- Fields >= MODULO clamp to MODULO-1.
- carryOut, overflowOut and underflowOut are 0 after a load.
REQ-017 Up step:
- Digit 0 increments.
- Digit k (k>0) increments only when digits 0..k-1 all equal MODULO-1.
- A digit at MODULO-1 that steps wraps to 0.
REQ-018 Down step:
- Digit 0 decrements.
- Digit k (k>0) decrements only when digits 0..k-1 all equal 0.
- A digit at 0 that steps wraps to MODULO-1.
REQ-019 Latency: digitsOut and flags reflect a step or load exactly one clock after it is sampled.
REQ-020 Flag timing: carryOut bits and the overflow/underflow flags are single-cycle pulses; they are 0 on any cycle with no step.
REQ-021 FSM states: RESET, COUNT, WRAP.
- RESET is entered asynchronously.
- RESET -> COUNT on the first clock edge; load and enable sampled on that edge are honoured.
- COUNT -> WRAP on a step that wraps every digit.
- WRAP -> WRAP on another full wrap; otherwise WRAP -> COUNT.
REQ-022 In WRAP, overflowOut = 1 if the wrapping step was up, else underflowOut = 1; both flags are never high together.
REQ-023 Changing upIn between consecutive steps takes effect on the next step; there is no dead cycle.
REQ-024 enableIn low: digitsOut holds and all flags are 0.

Reset
REQ-025 While resetIn is low, regardless of clkIn, the block holds:
- digitsOut = 0, carryOut = 0, overflowOut = 0, underflowOut = 0;
- FSM = RESET.
REQ-026 Reset asserted mid-count aborts any pending step or load; counting resumes from 0 after release.

Configuration
REQ-027 Macro MULTI_DIGIT_COUNTER_SATURATE_EN selects saturating behaviour; saturation replaces wrap.
- At all digits MODULO-1, an up step holds the value and sets overflowOut sticky.
- At all digits 0, a down step holds the value and sets underflowOut sticky.
- A sticky flag clears on a load, a step in the opposite direction, or reset.
- carryOut stays 0 on held steps.
REQ-028 Without the macro, wrap behaviour and single-cycle flags per REQ-017..REQ-022 apply.

Verification (DIGITS=4, MODULO=10 unless stated)
REQ-029 Reset mid-count: count to 0042, drop resetIn asynchronously between edges -> outputs 0 immediately; after release, 3 steps -> 0003.
REQ-030 Cascade carry: load 0999, up step -> 1000, carryOut = 0111, overflowOut = 0.
REQ-031 Full wrap: load 9999, up step -> 0000, overflowOut high exactly one cycle.
- With the saturate macro -> value stays 9999 and overflowOut stays high until a down step gives 9998.
REQ-032 Underflow: load 0000, down step -> 9999, underflowOut pulse, carryOut = 1111; then up step -> 0000 with overflowOut pulse.
REQ-033 Load priority: loadIn and enableIn high together with value 1234 -> 1234, no flags.
- Load of field 0xF into digit 0 -> digit 0 = 9.
REQ-034 DIGITS=2, MODULO=6: load 55, up step -> 00 with overflowOut.
- 36 continuous steps from 00 -> 00 again, exactly one overflow pulse.
